decode_pipe: RTL and testbench
==============================

DECODE_PIPE -- requirements
Module: decode_pipe

Interface
REQ-001 Parameter XLEN, default 32, datapath and register width in bits.
REQ-002 Parameter NREGS, default 32, architectural register count; address width RA = clog2(NREGS), max 5.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 if_valid  in  1  instruction/pc_plus4 from fetch are valid this cycle.
REQ-006 instruction  in  32  MIPS-format instruction word.
REQ-007 pc_plus4  in  XLEN  fetch PC+4, carried to execute.
REQ-008 wb_en, wb_addr, wb_data  in  1/RA/XLEN  register write-back port.
REQ-009 ex_ready  in  1  execute stage accepts the ID/EX register contents this cycle.
REQ-010 flush  in  1  kill the instruction being loaded into ID/EX (branch taken).
REQ-011 stall  out  1  fetch holds PC and instruction when high.
REQ-012 id_valid  out  1  ID/EX register holds a live instruction.
REQ-013 id_ctrl  out  10  registered {RegDst, Branch, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite, aluc[2:0]}.
REQ-014 id_rs_data, id_rt_data, id_imm, id_pc4  out  XLEN each  registered operands, extended immediate, PC+4.
REQ-015 id_rs, id_rt, id_rd  out  RA each  registered register addresses for forwarding/write-back selection.

Function
REQ-016 Decode: R-type (opcode 0) funct add/sub/and/or/slt -> aluc 010/110/000/001/111; lw, sw, beq, addi, andi, ori, slti.
REQ-017 Unknown opcode or funct decodes to all-zero control, so it is a no-op bubble.
REQ-018 Immediate: andi/ori zero-extend instruction[15:0] to XLEN; all others sign-extend.
REQ-019 Register file: NREGS x XLEN; register 0 reads 0, writes to it ignored; write on rising clk when wb_en.
REQ-020 Read bypass: same-cycle wb_en with wb_addr equal to a nonzero read address returns wb_data combinationally.
REQ-021 Load-use hazard: id_valid and id_ctrl.MemRead and id_rt != 0 and id_rt equals current rs, or current rt for R-type/sw/beq.
REQ-022 stall = (if_valid and hazard) or not ex_ready.
REQ-023 ID/EX update priority per edge: flush -> id_valid 0; else not ex_ready -> hold all; else hazard -> load bubble (id_valid 0, id_ctrl 0); else load decoded fields, id_valid = if_valid.
REQ-024 Latency: one cycle, instruction to ID/EX outputs; hazard inserts exactly one bubble.
REQ-025 Outputs other than stall are register outputs; no combinational path from inputs.

Reset
REQ-026 rst high clears id_valid, id_ctrl, all id_* data/address outputs and every register-file entry to 0, immediately and regardless of clk.
REQ-027 First valid load occurs on the first rising edge after rst deasserts; an in-flight instruction at reset is lost.

Structure
REQ-028 Shared package holds opcode/funct constants, aluc encodings and the control-field bit positions.
REQ-029 One sub-module, regfile_bypass, holds the register array, zero register and bypass; decode, hazard and pipeline register stay in decode_pipe.

Verification
REQ-030 Reset with random prior state -> all outputs 0; reading r5 after reset returns 0.
REQ-031 wb r3=0x1234 while decoding add r1,r3,r3 in the same cycle -> next edge id_rs_data = id_rt_data = 0x1234.
REQ-032 lw r2,0(r1) then add r4,r2,r5 -> stall high one cycle, one bubble (id_valid 0), add issues on the following edge.
REQ-033 andi r1,r2,0x8000 -> id_imm 0x00008000; addi r1,r2,0x8000 -> id_imm 0xFFFF8000.
REQ-034 ex_ready low 3 cycles -> ID/EX outputs frozen and stall high; flush asserted during a hazard -> id_valid 0 on the next edge.
REQ-035 Write 0xFFFF to r0 -> later read of r0 returns 0; rerun with XLEN=16, NREGS=16 passes.

Source files
------------

// File: rtl/decode_pipe_pkg.sv
// Shared decode constants for the ID stage: MIPS opcodes/functs, ALU control
// encodings and the bit layout of the packed control word carried into EX.
package decode_pipe_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [2:0] {
        ALUC_AND = 3'b000,
        ALUC_OR  = 3'b001,
        ALUC_ADD = 3'b010,
        ALUC_SUB = 3'b110,
        ALUC_SLT = 3'b111
    } aluc_e;

    // Control word layout: {RegDst, Branch, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite, aluc[2:0]}
    localparam int CTRL_W          = 10;
    localparam int CTRL_REG_DST    = 9;
    localparam int CTRL_BRANCH     = 8;
    localparam int CTRL_MEM_READ   = 7;
    localparam int CTRL_MEM_TO_REG = 6;
    localparam int CTRL_MEM_WRITE  = 5;
    localparam int CTRL_ALU_SRC    = 4;
    localparam int CTRL_REG_WRITE  = 3;
    localparam int CTRL_ALUC_LSB   = 0;

    // Instructions whose rt field is a source operand rather than a destination.
    function automatic logic reads_rt(input logic [5:0] opcode);
        return (opcode == OP_RTYPE) || (opcode == OP_SW) || (opcode == OP_BEQ);
    endfunction

endpackage

// File: rtl/decode_pipe_regfile_bypass.sv
// Architectural register file with hardwired zero register and same-cycle
// write-to-read bypass so decode sees write-back data without a cycle of delay.
module regfile_bypass #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    localparam int RA   = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wb_en,
    input  logic [RA-1:0]   wb_addr,
    input  logic [XLEN-1:0] wb_data,
    input  logic [RA-1:0]   rs_addr,
    input  logic [RA-1:0]   rt_addr,
    output logic [XLEN-1:0] rs_data,
    output logic [XLEN-1:0] rt_data
);

    logic [XLEN-1:0] regs [NREGS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_en && (wb_addr != '0)) begin
            regs[wb_addr] <= wb_data;
        end
    end

    // Register 0 is forced to zero on read as well, so a bypassed r0 write is also ignored.
    always_comb begin
        rs_data = '0;
        rt_data = '0;
        if (rs_addr != '0) begin
            rs_data = (wb_en && (wb_addr == rs_addr)) ? wb_data : regs[rs_addr];
        end
        if (rt_addr != '0) begin
            rt_data = (wb_en && (wb_addr == rt_addr)) ? wb_data : regs[rt_addr];
        end
    end

endmodule

// File: rtl/decode_pipe.sv
// MIPS instruction decode stage: control decode, immediate extension, register
// read, load-use hazard detection and the ID/EX pipeline register.
module decode_pipe
    import decode_pipe_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    localparam int RA   = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_valid,
    input  logic [31:0]       instruction,
    input  logic [XLEN-1:0]   pc_plus4,
    input  logic              wb_en,
    input  logic [RA-1:0]     wb_addr,
    input  logic [XLEN-1:0]   wb_data,
    input  logic              ex_ready,
    input  logic              flush,
    output logic              stall,
    output logic              id_valid,
    output logic [CTRL_W-1:0] id_ctrl,
    output logic [XLEN-1:0]   id_rs_data,
    output logic [XLEN-1:0]   id_rt_data,
    output logic [XLEN-1:0]   id_imm,
    output logic [XLEN-1:0]   id_pc4,
    output logic [RA-1:0]     id_rs,
    output logic [RA-1:0]     id_rt,
    output logic [RA-1:0]     id_rd
);

    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  rs_field;
    logic [4:0]  rt_field;
    logic [4:0]  rd_field;
    logic [15:0] imm16;

    assign opcode   = instruction[31:26];
    assign rs_field = instruction[25:21];
    assign rt_field = instruction[20:16];
    assign rd_field = instruction[15:11];
    assign funct    = instruction[5:0];
    assign imm16    = instruction[15:0];

    logic [RA-1:0] rs_addr;
    logic [RA-1:0] rt_addr;
    logic [RA-1:0] rd_addr;

    // Smaller register files simply ignore the upper address bits of each field.
    assign rs_addr = rs_field[RA-1:0];
    assign rt_addr = rt_field[RA-1:0];
    assign rd_addr = rd_field[RA-1:0];

    logic unused_fields;
    assign unused_fields = ^{instruction[10:6], rs_field, rt_field, rd_field};

    logic [CTRL_W-1:0] dec_ctrl;

    always_comb begin
        dec_ctrl = '0;
        case (opcode)
            OP_RTYPE: begin
                dec_ctrl[CTRL_REG_DST]   = 1'b1;
                dec_ctrl[CTRL_REG_WRITE] = 1'b1;
                case (funct)
                    FN_ADD:  dec_ctrl[CTRL_ALUC_LSB +: 3] = ALUC_ADD;
                    FN_SUB:  dec_ctrl[CTRL_ALUC_LSB +: 3] = ALUC_SUB;
                    FN_AND:  dec_ctrl[CTRL_ALUC_LSB +: 3] = ALUC_AND;
                    FN_OR:   dec_ctrl[CTRL_ALUC_LSB +: 3] = ALUC_OR;
                    FN_SLT:  dec_ctrl[CTRL_ALUC_LSB +: 3] = ALUC_SLT;
                    default: dec_ctrl = '0;
                endcase
            end
            OP_LW: begin
                dec_ctrl[CTRL_MEM_READ]      = 1'b1;
                dec_ctrl[CTRL_MEM_TO_REG]    = 1'b1;
                dec_ctrl[CTRL_ALU_SRC]       = 1'b1;
                dec_ctrl[CTRL_REG_WRITE]     = 1'b1;
                dec_ctrl[CTRL_ALUC_LSB +: 3] = ALUC_ADD;
            end
            OP_SW: begin
                dec_ctrl[CTRL_MEM_WRITE]     = 1'b1;
                dec_ctrl[CTRL_ALU_SRC]       = 1'b1;
                dec_ctrl[CTRL_ALUC_LSB +: 3] = ALUC_ADD;
            end
            OP_BEQ: begin
                dec_ctrl[CTRL_BRANCH]        = 1'b1;
                dec_ctrl[CTRL_ALUC_LSB +: 3] = ALUC_SUB;
            end
            OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: begin
                dec_ctrl[CTRL_ALU_SRC]   = 1'b1;
                dec_ctrl[CTRL_REG_WRITE] = 1'b1;
                case (opcode)
                    OP_ANDI: dec_ctrl[CTRL_ALUC_LSB +: 3] = ALUC_AND;
                    OP_ORI:  dec_ctrl[CTRL_ALUC_LSB +: 3] = ALUC_OR;
                    OP_SLTI: dec_ctrl[CTRL_ALUC_LSB +: 3] = ALUC_SLT;
                    default: dec_ctrl[CTRL_ALUC_LSB +: 3] = ALUC_ADD;
                endcase
            end
            default: dec_ctrl = '0;
        endcase
    end

    // Logical immediates are zero-extended; everything else (offsets, addi, slti) is signed.
    logic [XLEN-1:0] dec_imm;

    always_comb begin
        dec_imm = XLEN'($signed(imm16));
        if ((opcode == OP_ANDI) || (opcode == OP_ORI)) begin
            dec_imm = XLEN'(imm16);
        end
    end

    logic [XLEN-1:0] rs_data;
    logic [XLEN-1:0] rt_data;

    regfile_bypass #(
        .XLEN  (XLEN),
        .NREGS (NREGS)
    ) u_regfile (
        .clk     (clk),
        .rst     (rst),
        .wb_en   (wb_en),
        .wb_addr (wb_addr),
        .wb_data (wb_data),
        .rs_addr (rs_addr),
        .rt_addr (rt_addr),
        .rs_data (rs_data),
        .rt_data (rt_data)
    );

    // A load sitting in ID/EX cannot forward in time to an instruction that reads its target.
    logic hazard;

    assign hazard = id_valid && id_ctrl[CTRL_MEM_READ] && (id_rt != '0) &&
                    ((id_rt == rs_addr) || (reads_rt(opcode) && (id_rt == rt_addr)));

    assign stall = (if_valid && hazard) || !ex_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_valid   <= 1'b0;
            id_ctrl    <= '0;
            id_rs_data <= '0;
            id_rt_data <= '0;
            id_imm     <= '0;
            id_pc4     <= '0;
            id_rs      <= '0;
            id_rt      <= '0;
            id_rd      <= '0;
        end else if (flush) begin
            id_valid <= 1'b0;
            id_ctrl  <= '0;
        end else if (!ex_ready) begin
            id_valid <= id_valid;
        end else if (hazard) begin
            id_valid <= 1'b0;
            id_ctrl  <= '0;
        end else begin
            id_valid   <= if_valid;
            id_ctrl    <= dec_ctrl;
            id_rs_data <= rs_data;
            id_rt_data <= rt_data;
            id_imm     <= dec_imm;
            id_pc4     <= pc_plus4;
            id_rs      <= rs_addr;
            id_rt      <= rt_addr;
            id_rd      <= rd_addr;
        end
    end

endmodule

// File: tb/tb_decode_pipe.sv
// Directed test of the decode stage: reset, bypass, decode table, immediates,
// load-use stalls, back-pressure, flush and the zero register.
module tb_decode_pipe;

    localparam int TB_XLEN  = 32;
    localparam int TB_NREGS = 32;
    localparam int TB_RA    = $clog2(TB_NREGS);

    localparam logic [9:0] CTRL_ADD  = 10'b1000001010;
    localparam logic [9:0] CTRL_SUB  = 10'b1000001110;
    localparam logic [9:0] CTRL_SLT  = 10'b1000001111;
    localparam logic [9:0] CTRL_LW   = 10'b0011011010;
    localparam logic [9:0] CTRL_SW   = 10'b0000110010;
    localparam logic [9:0] CTRL_BEQ  = 10'b0100000110;
    localparam logic [9:0] CTRL_ADDI = 10'b0000011010;
    localparam logic [9:0] CTRL_ANDI = 10'b0000011000;
    localparam logic [9:0] CTRL_ORI  = 10'b0000011001;

    logic               clk;
    logic               rst;
    logic               if_valid;
    logic [31:0]        instruction;
    logic [TB_XLEN-1:0] pc_plus4;
    logic               wb_en;
    logic [TB_RA-1:0]   wb_addr;
    logic [TB_XLEN-1:0] wb_data;
    logic               ex_ready;
    logic               flush;
    logic               stall;
    logic               id_valid;
    logic [9:0]         id_ctrl;
    logic [TB_XLEN-1:0] id_rs_data;
    logic [TB_XLEN-1:0] id_rt_data;
    logic [TB_XLEN-1:0] id_imm;
    logic [TB_XLEN-1:0] id_pc4;
    logic [TB_RA-1:0]   id_rs;
    logic [TB_RA-1:0]   id_rt;
    logic [TB_RA-1:0]   id_rd;

    int errors = 0;
    int checks = 0;

    decode_pipe #(
        .XLEN  (TB_XLEN),
        .NREGS (TB_NREGS)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .if_valid    (if_valid),
        .instruction (instruction),
        .pc_plus4    (pc_plus4),
        .wb_en       (wb_en),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .ex_ready    (ex_ready),
        .flush       (flush),
        .stall       (stall),
        .id_valid    (id_valid),
        .id_ctrl     (id_ctrl),
        .id_rs_data  (id_rs_data),
        .id_rt_data  (id_rt_data),
        .id_imm      (id_imm),
        .id_pc4      (id_pc4),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_rd       (id_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input logic [5:0] fn);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt, input logic [15:0] imm);
        return {op, 5'(rs), 5'(rt), imm};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        wb_en = 1'b1; wb_addr = TB_RA'(5); wb_data = TB_XLEN'(32'hA5A5_5A5A);
        if_valid = 1'b1; instruction = enc_i(6'h23, 1, 2, 16'h0010); pc_plus4 = TB_XLEN'(32'h40);
        tick();
        wb_en = 1'b0;
        instruction = enc_i(6'h08, 3, 4, 16'hFFFF); pc_plus4 = TB_XLEN'(32'h44);
        tick();
        #2 rst = 1'b1;
        #1;
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", id_valid); end
        checks++; if (id_ctrl !== 10'd0) begin errors++; $display("FAIL reset_ctrl got=%b exp=0", id_ctrl); end
        checks++;
        if ({id_rs_data, id_rt_data, id_imm, id_pc4} !== '0 || {id_rs, id_rt, id_rd} !== '0) begin
            errors++;
            $display("FAIL reset_data got rs=%h rt=%h imm=%h pc4=%h addr=%h/%h/%h exp=0",
                     id_rs_data, id_rt_data, id_imm, id_pc4, id_rs, id_rt, id_rd);
        end
        tick();
        rst = 1'b0;
        instruction = enc_r(5, 0, 6, 6'h20); pc_plus4 = TB_XLEN'(32'h48);
        tick();
        checks++; if (id_rs_data !== '0) begin errors++; $display("FAIL reset_r5 got=%h exp=0", id_rs_data); end
        checks++; if (id_valid !== 1'b1) begin errors++; $display("FAIL reset_first_load got=%b exp=1", id_valid); end
        checks++; if (id_ctrl !== CTRL_ADD) begin errors++; $display("FAIL reset_add_ctrl got=%b exp=%b", id_ctrl, CTRL_ADD); end
    endtask

    task automatic test_bypass();
        wb_en = 1'b1; wb_addr = TB_RA'(3); wb_data = TB_XLEN'(32'h1234);
        instruction = enc_r(3, 3, 1, 6'h20); pc_plus4 = TB_XLEN'(32'h104);
        tick();
        wb_en = 1'b0;
        checks++; if (id_rs_data !== TB_XLEN'(32'h1234)) begin errors++; $display("FAIL bypass_rs got=%h exp=1234", id_rs_data); end
        checks++; if (id_rt_data !== TB_XLEN'(32'h1234)) begin errors++; $display("FAIL bypass_rt got=%h exp=1234", id_rt_data); end
        checks++; if (id_pc4 !== TB_XLEN'(32'h104)) begin errors++; $display("FAIL bypass_pc4 got=%h exp=104", id_pc4); end
        checks++; if (id_rd !== TB_RA'(1)) begin errors++; $display("FAIL bypass_rd got=%0d exp=1", id_rd); end
        instruction = enc_r(0, 3, 2, 6'h22);
        tick();
        checks++; if (id_rt_data !== TB_XLEN'(32'h1234)) begin errors++; $display("FAIL regfile_r3 got=%h exp=1234", id_rt_data); end
        checks++; if (id_ctrl !== CTRL_SUB) begin errors++; $display("FAIL sub_ctrl got=%b exp=%b", id_ctrl, CTRL_SUB); end
    endtask

    task automatic test_decode();
        logic [31:0] insns [7];
        logic [9:0]  exp   [7];
        insns[0] = enc_r(1, 2, 3, 6'h2A);        exp[0] = CTRL_SLT;
        insns[1] = enc_i(6'h2B, 1, 2, 16'h0004); exp[1] = CTRL_SW;
        insns[2] = enc_i(6'h04, 1, 2, 16'h0008); exp[2] = CTRL_BEQ;
        insns[3] = enc_i(6'h0D, 1, 2, 16'h00FF); exp[3] = CTRL_ORI;
        insns[4] = enc_r(1, 2, 3, 6'h21);        exp[4] = 10'd0;
        insns[5] = enc_i(6'h3F, 1, 2, 16'h0000); exp[5] = 10'd0;
        insns[6] = enc_i(6'h0C, 1, 2, 16'h00F0); exp[6] = CTRL_ANDI;
        for (int i = 0; i < 7; i++) begin
            instruction = insns[i];
            tick();
            checks++;
            if (id_ctrl !== exp[i]) begin
                errors++;
                $display("FAIL decode_%0d got=%b exp=%b", i, id_ctrl, exp[i]);
            end
        end
    endtask

    task automatic test_immediate();
        instruction = enc_i(6'h0C, 2, 1, 16'h8000);
        tick();
        checks++; if (id_imm !== TB_XLEN'(32'h0000_8000)) begin errors++; $display("FAIL imm_andi got=%h exp=00008000", id_imm); end
        instruction = enc_i(6'h08, 2, 1, 16'h8000);
        tick();
        checks++; if (id_imm !== TB_XLEN'(32'hFFFF_8000)) begin errors++; $display("FAIL imm_addi got=%h exp=ffff8000", id_imm); end
        checks++; if (id_ctrl !== CTRL_ADDI) begin errors++; $display("FAIL addi_ctrl got=%b exp=%b", id_ctrl, CTRL_ADDI); end
    endtask

    task automatic test_load_use();
        instruction = enc_i(6'h23, 1, 2, 16'h0000); pc_plus4 = TB_XLEN'(32'h200);
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lu_pre_stall got=%b exp=0", stall); end
        tick();
        checks++; if (id_ctrl !== CTRL_LW) begin errors++; $display("FAIL lu_lw_ctrl got=%b exp=%b", id_ctrl, CTRL_LW); end
        instruction = enc_r(2, 5, 4, 6'h20); pc_plus4 = TB_XLEN'(32'h204);
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL lu_stall got=%b exp=1", stall); end
        tick();
        checks++; if (id_valid !== 1'b0 || id_ctrl !== 10'd0) begin errors++; $display("FAIL lu_bubble got valid=%b ctrl=%b exp 0/0", id_valid, id_ctrl); end
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lu_stall_release got=%b exp=0", stall); end
        tick();
        checks++;
        if (id_valid !== 1'b1 || id_rd !== TB_RA'(4) || id_rs !== TB_RA'(2) || id_rt !== TB_RA'(5) || id_pc4 !== TB_XLEN'(32'h204)) begin
            errors++;
            $display("FAIL lu_issue got valid=%b rd=%0d rs=%0d rt=%0d pc4=%h exp 1/4/2/5/204", id_valid, id_rd, id_rs, id_rt, id_pc4);
        end
        // lw then I-type whose rt is only a destination, and lw to r0: neither may stall
        instruction = enc_i(6'h23, 1, 2, 16'h0000);
        tick();
        instruction = enc_i(6'h08, 3, 2, 16'h0001);
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lu_itype_rt got=%b exp=0", stall); end
        instruction = enc_i(6'h23, 1, 0, 16'h0000);
        tick();
        tick();
        instruction = enc_r(0, 0, 4, 6'h20);
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lu_r0 got=%b exp=0", stall); end
        instruction = enc_i(6'h23, 1, 2, 16'h0000);
        tick();
        instruction = enc_i(6'h04, 3, 2, 16'h0004);
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL lu_beq_rt got=%b exp=1", stall); end
        tick();
    endtask

    task automatic test_ex_ready();
        instruction = enc_i(6'h08, 1, 9, 16'h0005); pc_plus4 = TB_XLEN'(32'h300);
        tick();
        instruction = enc_r(1, 2, 3, 6'h22); pc_plus4 = TB_XLEN'(32'h304);
        ex_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (stall !== 1'b1) begin errors++; $display("FAIL exr_stall_%0d got=%b exp=1", i, stall); end
            tick();
            checks++;
            if (id_pc4 !== TB_XLEN'(32'h300) || id_imm !== TB_XLEN'(5) || id_ctrl !== CTRL_ADDI || id_valid !== 1'b1) begin
                errors++;
                $display("FAIL exr_hold_%0d got pc4=%h imm=%h ctrl=%b valid=%b exp 300/5/%b/1", i, id_pc4, id_imm, id_ctrl, id_valid, CTRL_ADDI);
            end
        end
        ex_ready = 1'b1;
        tick();
        checks++; if (id_pc4 !== TB_XLEN'(32'h304) || id_ctrl !== CTRL_SUB) begin errors++; $display("FAIL exr_resume got pc4=%h ctrl=%b exp 304/%b", id_pc4, id_ctrl, CTRL_SUB); end
    endtask

    task automatic test_flush();
        instruction = enc_i(6'h23, 1, 2, 16'h0000); pc_plus4 = TB_XLEN'(32'h400);
        tick();
        instruction = enc_r(2, 5, 4, 6'h20); pc_plus4 = TB_XLEN'(32'h404);
        flush = 1'b1;
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL flush_stall got=%b exp=1", stall); end
        tick();
        flush = 1'b0;
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got=%b exp=0", id_valid); end
        tick();
        checks++; if (id_valid !== 1'b1 || id_rd !== TB_RA'(4)) begin errors++; $display("FAIL flush_after got valid=%b rd=%0d exp 1/4", id_valid, id_rd); end
    endtask

    task automatic test_zero_reg();
        wb_en = 1'b1; wb_addr = '0; wb_data = TB_XLEN'(32'hFFFF);
        instruction = enc_r(0, 0, 1, 6'h20);
        tick();
        checks++; if (id_rs_data !== '0) begin errors++; $display("FAIL r0_bypass got=%h exp=0", id_rs_data); end
        wb_en = 1'b0;
        tick();
        checks++; if (id_rs_data !== '0 || id_rt_data !== '0) begin errors++; $display("FAIL r0_read got=%h/%h exp=0/0", id_rs_data, id_rt_data); end
    endtask

    initial begin
        rst = 1'b1;
        if_valid = 1'b0; instruction = '0; pc_plus4 = '0;
        wb_en = 1'b0; wb_addr = '0; wb_data = '0;
        ex_ready = 1'b1; flush = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        test_reset();
        test_bypass();
        test_decode();
        test_immediate();
        test_load_use();
        test_ex_ready();
        test_flush();
        test_zero_reg();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
